// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-cold column drive, debounced press/release,
// single key_valid pulse and {row,col} key code per accepted press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] rows_sync,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);
    // state    | meaning
    // SCAN     | walk the columns, sample rows at the end of each dwell
    // DEBOUNCE | column frozen, counting consecutive low samples of the latched row
    // HELD     | key accepted, waiting for the latched row to go high
    // RELEASE  | counting consecutive high samples before resuming the scan

    localparam int DW = $clog2(SCAN_DIV) + 1;
    localparam int CW = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t         state, state_nxt;
    logic [1:0]     col_idx, col_nxt;
    logic [1:0]     row_idx, row_nxt;
    logic [DW-1:0]  dwell, dwell_nxt;
    logic [CW-1:0]  dbc, dbc_nxt;
    logic           valid_nxt, held_nxt;
    logic [3:0]     code_nxt;
    logic [1:0]     low_idx;
    logic           any_low, row_low;

    assign any_low = ~&rows_sync;
    assign row_low = ~rows_sync[row_idx];

    // lowest-index closed row wins when several are low in one column
    always_comb begin
        if (!rows_sync[0])      low_idx = 2'd0;
        else if (!rows_sync[1]) low_idx = 2'd1;
        else if (!rows_sync[2]) low_idx = 2'd2;
        else                    low_idx = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell     <= '0;
            dbc       <= '0;
            cols      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            row_idx   <= row_nxt;
            dwell     <= dwell_nxt;
            dbc       <= dbc_nxt;
            cols      <= ~(4'b0001 << col_nxt);
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
            key_held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:     if (dwell == DWELL_LAST && any_low) state_nxt = DEBOUNCE;
            DEBOUNCE: if (!row_low) state_nxt = SCAN;
                      else if (dbc == CNT_LAST) state_nxt = HELD;
            HELD:     if (!row_low) state_nxt = RELEASE;
            RELEASE:  if (row_low) state_nxt = HELD;
                      else if (dbc == CNT_LAST) state_nxt = SCAN;
            default:  state_nxt = SCAN;
        endcase
    end

    always_comb begin
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        dwell_nxt = dwell;
        dbc_nxt   = dbc;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
        code_nxt  = key_code;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (any_low) begin
                        row_nxt = low_idx;
                        dbc_nxt = '0;
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell + DWELL_ONE;
                end
            end
            DEBOUNCE: begin
                if (row_low) begin
                    if (dbc == CNT_LAST) begin
                        valid_nxt = 1'b1;
                        held_nxt  = 1'b1;
                        code_nxt  = {row_idx, col_idx};
                        dbc_nxt   = '0;
                    end else begin
                        dbc_nxt = dbc + CNT_ONE;
                    end
                end else begin
                    col_nxt   = col_idx + 2'd1;
                    dwell_nxt = '0;
                end
            end
            HELD: begin
                held_nxt = 1'b1;
                if (!row_low) dbc_nxt = '0;
            end
            RELEASE: begin
                if (row_low) begin
                    dbc_nxt = '0;
                end else if (dbc == CNT_LAST) begin
                    held_nxt  = 1'b0;
                    col_nxt   = col_idx + 2'd1;
                    dwell_nxt = '0;
                    dbc_nxt   = '0;
                end else begin
                    dbc_nxt = dbc + CNT_ONE;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a scan-walk vector table plus
// hand-written press, bounce, release and reset sequences.
module tb_keypad_scan_ctrl;
    logic       clk;
    logic       nrst;
    logic [3:0] rows_sync;
    logic [3:0] cols;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] rows;
        logic [3:0] cols;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;

    vec_t scan_tbl[16];

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rows_sync (rows_sync),
        .cols      (cols),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] c, input logic v,
                              input logic h, input logic [3:0] k);
        check({name, ".cols"}, cols, c);
        check({name, ".valid"}, {3'b0, key_valid}, {3'b0, v});
        check({name, ".held"}, {3'b0, key_held}, {3'b0, h});
        check({name, ".code"}, key_code, k);
    endtask

    // drive r for n edges, requiring key_valid to stay low throughout
    task automatic hold_quiet(input string name, input logic [3:0] r, input int n);
        rows_sync = r;
        for (int i = 0; i < n; i++) begin
            step();
            check(name, {3'b0, key_valid}, 4'h0);
        end
    endtask

    task automatic wait_cols(input logic [3:0] c);
        int k;
        rows_sync = 4'hF;
        k = 0;
        while (cols !== c && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (cols !== c) begin
            errors++;
            $display("FAIL wait_cols: got %b expected %b", cols, c);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            scan_tbl[i].rows  = 4'hF;
            scan_tbl[i].cols  = ~(4'b0001 << (((i + 1) / 4) % 4));
            scan_tbl[i].valid = 1'b0;
            scan_tbl[i].held  = 1'b0;
            scan_tbl[i].code  = 4'h0;
        end

        // 1: reset and free-running scan
        nrst = 1'b0;
        rows_sync = 4'hF;
        step();
        check_outs("reset", 4'b1110, 1'b0, 1'b0, 4'h0);
        nrst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rows_sync = scan_tbl[i].rows;
            step();
            check_outs($sformatf("scan[%0d]", i), scan_tbl[i].cols, scan_tbl[i].valid,
                       scan_tbl[i].held, scan_tbl[i].code);
        end

        // 2: row2 in col1, held 30 cycles
        wait_cols(4'b1101);
        hold_quiet("press_quiet", 4'b1011, 11);
        check_outs("press_pre", 4'b1101, 1'b0, 1'b0, 4'h0);
        step();
        check_outs("press_pulse", 4'b1101, 1'b1, 1'b1, 4'h9);
        hold_quiet("press_hold", 4'b1011, 18);
        check_outs("press_held", 4'b1101, 1'b0, 1'b1, 4'h9);
        hold_quiet("release_wait", 4'hF, 8);
        check_outs("release_pre", 4'b1101, 1'b0, 1'b1, 4'h9);
        step();
        check_outs("release_done", 4'b1011, 1'b0, 1'b0, 4'h9);

        // 3: press bounce in col1
        wait_cols(4'b1101);
        hold_quiet("bounce_detect", 4'b1011, 4);
        hold_quiet("bounce_low", 4'b1011, 3);
        rows_sync = 4'hF;
        step();
        check_outs("bounce_abandon", 4'b1011, 1'b0, 1'b0, 4'h9);
        hold_quiet("bounce_after", 4'hF, 3);
        check_outs("bounce_after_st", 4'b1011, 1'b0, 1'b0, 4'h9);

        // 4: release bounce in HELD, row1 col0
        wait_cols(4'b1110);
        hold_quiet("p4_quiet", 4'b1101, 11);
        step();
        check_outs("p4_pulse", 4'b1110, 1'b1, 1'b1, 4'h4);
        hold_quiet("p4_rbounce", 4'hF, 3);
        hold_quiet("p4_relow", 4'b1101, 12);
        check_outs("p4_still_held", 4'b1110, 1'b0, 1'b1, 4'h4);
        hold_quiet("p4_release", 4'hF, 8);
        check_outs("p4_release_pre", 4'b1110, 1'b0, 1'b1, 4'h4);
        step();
        check_outs("p4_release_done", 4'b1101, 1'b0, 1'b0, 4'h4);

        // 5: rows 0 and 3 low in col0 -> row0; then row3 in col2
        wait_cols(4'b1110);
        hold_quiet("p5a_quiet", 4'b0110, 11);
        step();
        check_outs("p5a_pulse", 4'b1110, 1'b1, 1'b1, 4'h0);
        hold_quiet("p5a_release", 4'hF, 9);
        check_outs("p5a_done", 4'b1101, 1'b0, 1'b0, 4'h0);
        wait_cols(4'b1011);
        hold_quiet("p5b_quiet", 4'b0111, 11);
        step();
        check_outs("p5b_pulse", 4'b1011, 1'b1, 1'b1, 4'hE);
        hold_quiet("p5b_release", 4'hF, 9);
        check_outs("p5b_done", 4'b0111, 1'b0, 1'b0, 4'hE);

        // 6: reset mid-debounce, then a fresh full press
        wait_cols(4'b1110);
        hold_quiet("p6_detect", 4'b1110, 4);
        hold_quiet("p6_count", 4'b1110, 5);
        nrst = 1'b0;
        step();
        check_outs("p6_reset", 4'b1110, 1'b0, 1'b0, 4'h0);
        nrst = 1'b1;
        hold_quiet("p6_fresh", 4'b1110, 11);
        check_outs("p6_fresh_pre", 4'b1110, 1'b0, 1'b0, 4'h0);
        step();
        check_outs("p6_pulse", 4'b1110, 1'b1, 1'b1, 4'h0);
        hold_quiet("p6_release", 4'hF, 9);
        check_outs("p6_done", 4'b1101, 1'b0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
